// File: rtl/tff_universal_reg_if.sv
// Bus interface for tff_universal_reg: control/data inputs plus Q and TC outputs.
// The master drives EN/MODE/DIR/D; the slave (the register) drives Q and TC.
interface tff_universal_reg_if #(
    parameter int WIDTH = 8
);
    logic             EN;
    logic [1:0]       MODE;
    logic             DIR;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             TC;

    modport master (output EN, MODE, DIR, D, input Q, TC);
    modport slave  (input EN, MODE, DIR, D, output Q, TC);
endinterface

// File: rtl/tff_universal_reg.sv
// Multi-mode register built from T flip-flops: hold, load, toggle-mask, up/down count.
// Optional macro TFFREG_SATURATE_EN makes count mode stop at its terminal value instead of wrapping.
module tff_universal_reg #(
    parameter int WIDTH = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    tff_universal_reg_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_TOGGLE = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] cnt_t;
    logic [WIDTH-1:0] low_mask;
    logic             tc;

    assign mode = mode_e'(bus.MODE);

    // T[i] of the counter is the AND of all lower bits; bits at or above i are masked to 1.
    always_comb begin
        up_t     = '0;
        dn_t     = '0;
        low_mask = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            low_mask = (WIDTH'(1) << i) - WIDTH'(1);
            up_t[i]  = &(q_q | ~low_mask);
            dn_t[i]  = &(~q_q | ~low_mask);
        end
    end

    always_comb begin
        tc = 1'b0;
        if (bus.EN && (mode == MODE_COUNT)) begin
            tc = bus.DIR ? (&q_q) : ~(|q_q);
        end
    end

    always_comb begin
        cnt_t = bus.DIR ? up_t : dn_t;
`ifdef TFFREG_SATURATE_EN
        if (tc) begin
            cnt_t = '0;
        end
`endif
        t = '0;
        if (bus.EN) begin
            case (mode)
                MODE_HOLD:   t = '0;
                MODE_LOAD:   t = q_q ^ bus.D;
                MODE_TOGGLE: t = bus.D;
                MODE_COUNT:  t = cnt_t;
                default:     t = '0;
            endcase
        end
        q_d = q_q ^ t;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.Q  = q_q;
    assign bus.TC = tc;
endmodule

// File: tb/tb_tff_universal_reg.sv
// Self-checking bench for tff_universal_reg (WIDTH=8 and WIDTH=4 instances) against an arithmetic model.
// Honours TFFREG_SATURATE_EN in both the model and the directed expectations.
module tb_tff_universal_reg;
    logic CLK;
    logic RST_N;

    tff_universal_reg_if #(.WIDTH(8)) bus8 ();
    tff_universal_reg_if #(.WIDTH(4)) bus4 ();

    tff_universal_reg #(.WIDTH(8)) dut8 (.CLK(CLK), .RST_N(RST_N), .bus(bus8.slave));
    tff_universal_reg #(.WIDTH(4)) dut4 (.CLK(CLK), .RST_N(RST_N), .bus(bus4.slave));

    int unsigned vectors;
    int unsigned n_cmp;
    int unsigned miscompares;
    int unsigned m8;
    int unsigned m4;
    bit          armed;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: next value from plain modular arithmetic.
    function automatic int unsigned model_next(int unsigned q, logic en, logic [1:0] mode,
                                               logic dir, int unsigned d, int unsigned w);
        int unsigned mx;
        mx = (32'd1 << w) - 32'd1;
        if (!en) return q;
        case (mode)
            2'b01: return d & mx;
            2'b10: return (q ^ d) & mx;
            2'b11: begin
`ifdef TFFREG_SATURATE_EN
                if (dir && q == mx) return q;
                if (!dir && q == 0) return q;
`endif
                return dir ? ((q + 1) & mx) : ((q - 1) & mx);
            end
            default: return q;
        endcase
    endfunction

    function automatic logic model_tc(int unsigned q, logic en, logic [1:0] mode,
                                      logic dir, int unsigned w);
        int unsigned mx;
        mx = (32'd1 << w) - 32'd1;
        return en && (mode == 2'b11) && (dir ? (q == mx) : (q == 0));
    endfunction

    always @(posedge CLK) begin
        if (!RST_N) begin
            m8    <= 0;
            m4    <= 0;
            armed <= 1'b1;
        end else begin
            m8 <= model_next(m8, bus8.EN, bus8.MODE, bus8.DIR, 32'(bus8.D), 8);
            m4 <= model_next(m4, bus4.EN, bus4.MODE, bus4.DIR, 32'(bus4.D), 4);
        end
    end

    // Per-cycle compare; inputs are stable at the falling edge.
    always @(negedge CLK) begin
        if (armed) begin
            n_cmp = n_cmp + 4;
            if (bus8.Q !== 8'(m8)) begin
                miscompares++;
                $display("FAIL q8 t=%0t got=%h want=%h", $time, bus8.Q, 8'(m8));
            end
            if (bus8.TC !== model_tc(m8, bus8.EN, bus8.MODE, bus8.DIR, 8)) begin
                miscompares++;
                $display("FAIL tc8 t=%0t got=%b want=%b", $time, bus8.TC,
                         model_tc(m8, bus8.EN, bus8.MODE, bus8.DIR, 8));
            end
            if (bus4.Q !== 4'(m4)) begin
                miscompares++;
                $display("FAIL q4 t=%0t got=%h want=%h", $time, bus4.Q, 4'(m4));
            end
            if (bus4.TC !== model_tc(m4, bus4.EN, bus4.MODE, bus4.DIR, 4)) begin
                miscompares++;
                $display("FAIL tc4 t=%0t got=%b want=%b", $time, bus4.TC,
                         model_tc(m4, bus4.EN, bus4.MODE, bus4.DIR, 4));
            end
        end
    end

    task automatic step8(input logic rst_n, input logic en, input logic [1:0] mode,
                         input logic dir, input logic [7:0] d);
        @(negedge CLK);
        #1;
        RST_N     = rst_n;
        bus8.EN   = en;
        bus8.MODE = mode;
        bus8.DIR  = dir;
        bus8.D    = d;
        vectors++;
        @(posedge CLK);
        #1;
    endtask

    task automatic step4(input logic en, input logic [1:0] mode, input logic dir,
                         input logic [3:0] d);
        @(negedge CLK);
        #1;
        RST_N     = 1'b1;
        bus4.EN   = en;
        bus4.MODE = mode;
        bus4.DIR  = dir;
        bus4.D    = d;
        vectors++;
        @(posedge CLK);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    int unsigned tc_pulses;

    initial begin
        vectors     = 0;
        n_cmp       = 0;
        miscompares = 0;
        armed       = 1'b0;
        m8          = 0;
        m4          = 0;
        RST_N       = 1'b0;
        bus8.EN = 1'b0; bus8.MODE = 2'b00; bus8.DIR = 1'b0; bus8.D = '0;
        bus4.EN = 1'b0; bus4.MODE = 2'b00; bus4.DIR = 1'b0; bus4.D = '0;

        // Reset with a pending load that must be ignored.
        step8(1'b0, 1'b1, 2'b01, 1'b0, 8'hA5);
        step8(1'b0, 1'b1, 2'b01, 1'b0, 8'hA5);
        lit("reset_q", 32'(bus8.Q), 32'h00);
        lit("reset_q4", 32'(bus4.Q), 32'h0);
        step8(1'b1, 1'b1, 2'b01, 1'b0, 8'hA5);
        lit("load_a5", 32'(bus8.Q), 32'hA5);

        // Load / toggle / hold.
        step8(1'b1, 1'b1, 2'b01, 1'b0, 8'h3C);
        step8(1'b1, 1'b1, 2'b10, 1'b0, 8'h0F);
        lit("toggle_33", 32'(bus8.Q), 32'h33);
        for (int i = 0; i < 3; i++) step8(1'b1, 1'b0, 2'b11, 1'b1, 8'hFF);
        lit("hold_en0", 32'(bus8.Q), 32'h33);
        lit("tc_en0", 32'(bus8.TC), 32'h0);

        // Up wrap.
        step8(1'b1, 1'b1, 2'b01, 1'b0, 8'hFE);
        step8(1'b1, 1'b1, 2'b11, 1'b1, 8'h00);
        lit("up1_q", 32'(bus8.Q), 32'hFF);
        lit("up1_tc", 32'(bus8.TC), 32'h1);
        step8(1'b1, 1'b1, 2'b11, 1'b1, 8'h00);
`ifdef TFFREG_SATURATE_EN
        lit("up2_q", 32'(bus8.Q), 32'hFF);
        lit("up2_tc", 32'(bus8.TC), 32'h1);
`else
        lit("up2_q", 32'(bus8.Q), 32'h00);
        lit("up2_tc", 32'(bus8.TC), 32'h0);
`endif

        // Down wrap.
        step8(1'b1, 1'b1, 2'b01, 1'b0, 8'h01);
        step8(1'b1, 1'b1, 2'b11, 1'b0, 8'h00);
        lit("dn1_q", 32'(bus8.Q), 32'h00);
        lit("dn1_tc", 32'(bus8.TC), 32'h1);
        step8(1'b1, 1'b1, 2'b11, 1'b0, 8'h00);
`ifdef TFFREG_SATURATE_EN
        lit("dn2_q", 32'(bus8.Q), 32'h00);
`else
        lit("dn2_q", 32'(bus8.Q), 32'hFF);
`endif

        // Reset mid-count.
        step8(1'b1, 1'b1, 2'b01, 1'b0, 8'h10);
        for (int i = 0; i < 5; i++) step8(1'b1, 1'b1, 2'b11, 1'b1, 8'h00);
        lit("cnt_15", 32'(bus8.Q), 32'h15);
        step8(1'b0, 1'b1, 2'b11, 1'b1, 8'h00);
        lit("midrst_q", 32'(bus8.Q), 32'h00);
        step8(1'b1, 1'b1, 2'b11, 1'b1, 8'h00);
        lit("resume_q", 32'(bus8.Q), 32'h01);

        // Width-4 instance counting through its wrap.
        step8(1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
        step4(1'b1, 2'b01, 1'b0, 4'h0);
        lit("w4_zero", 32'(bus4.Q), 32'h0);
        tc_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step4(1'b1, 2'b11, 1'b1, 4'h0);
            if (bus4.TC === 1'b1) tc_pulses++;
        end
`ifdef TFFREG_SATURATE_EN
        lit("w4_q20", 32'(bus4.Q), 32'hF);
        lit("w4_tc_pulses", 32'(tc_pulses), 32'd6);
`else
        lit("w4_q20", 32'(bus4.Q), 32'h4);
        lit("w4_tc_pulses", 32'(tc_pulses), 32'd1);
`endif

        // Randomized traffic on both instances, checked by the per-cycle compare.
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            #1;
            RST_N     = ($urandom_range(0, 39) != 0);
            bus8.EN   = ($urandom_range(0, 7) != 0);
            bus8.MODE = 2'($urandom);
            bus8.DIR  = 1'($urandom);
            bus8.D    = 8'($urandom);
            bus4.EN   = ($urandom_range(0, 7) != 0);
            bus4.MODE = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'($urandom);
            bus4.DIR  = 1'($urandom);
            bus4.D    = 4'($urandom);
            vectors++;
            @(posedge CLK);
        end

        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
